qrisc32_decode: RTL and testbench

Instruction decode stage of the Qrisc32 pipeline. It accepts 32-bit instruction words with their PC from fetch over a valid/ready handshake and owns the 32x32 register file. It decodes each word into a `risc_pack::pipe_struct_t` and presents it to EX with a registered output and a one-entry skid buffer, so it sustains one instruction per cycle under downstream backpressure.

---
 rtl/qrisc32_decode.sv | 261 ++++++++++++++++++++++++++
 tb/tb_qrisc32_decode.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qrisc32_decode.sv
// Qrisc32 decode stage.
// Accepts {instr, pc} from fetch over valid/ready, reads the 32x32 register
// file (write-first bypass from WB) and presents a decoded pipe_struct_t to EX
// through an output register backed by a one-entry skid buffer.
// Ports:
//   clk, areset            clock, asynchronous active-high reset
//   flush                  drop held and offered instructions
//   instr_valid/ready      fetch handshake; instr, pc payload
//   out_valid/ready        EX handshake; out_pipe, out_illegal payload
//   wb_en, wb_addr, wb_data  register file write port

package risc_pack;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [3:0] OP_LDR    = 4'd0;
  localparam logic [3:0] OP_STR    = 4'd1;
  localparam logic [3:0] OP_JMPUNC = 4'd2;
  localparam logic [3:0] OP_JMPF   = 4'd3;
  localparam logic [3:0] OP_ALU    = 4'd4;
  localparam logic [3:0] OP_LDRF   = 4'd5;

  typedef struct packed {
    logic [3:0]      op;
    logic [1:0]      ty;
    logic [2:0]      alu;
    logic            ofs_r;
    logic [2:0]      inc;
    logic [RW-1:0]   src_r2;
    logic [RW-1:0]   src_r1;
    logic [RW-1:0]   dst_r;
    logic [XLEN-1:0] val_r1;
    logic [XLEN-1:0] val_r2;
    logic [XLEN-1:0] val_dst;
    logic [3:0]      incr_r2;
    logic            incr_r2_enable;
    logic            read_mem;
    logic            write_mem;
    logic            write_reg;
    logic            jmpunc;
    logic            jmpz;
    logic            jmpnz;
    logic            jmpc;
    logic            jmpnc;
    logic            and_op;
    logic            or_op;
    logic            xor_op;
    logic            add_op;
    logic            mul_op;
    logic            shl_op;
    logic            shr_op;
    logic            cmp_op;
    logic            ldrf_op;
  } pipe_struct_t;
endpackage

module qrisc32_decode
  import risc_pack::*;
#(
  parameter logic [31:0] RF_RESET_VAL = 32'h0
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         flush,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  output logic         out_valid,
  input  logic         out_ready,
  output pipe_struct_t out_pipe,
  output logic         out_illegal,
  input  logic         wb_en,
  input  logic [4:0]   wb_addr,
  input  logic [31:0]  wb_data
);

  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rd_r1, rd_r2, rd_dst;

  pipe_struct_t dec;
  logic         dec_ill;
  logic         inc_en;
  logic [3:0]   cond;

  pipe_struct_t out_pipe_q, out_pipe_d, sk_pipe_q, sk_pipe_d;
  logic         out_valid_q, out_valid_d, sk_valid_q, sk_valid_d;
  logic         out_ill_q, out_ill_d, sk_ill_q, sk_ill_d;
  logic         accept;

  // Register file; WB writes land regardless of flush or stall.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= RF_RESET_VAL;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Write-first read ports.
  assign rd_r1  = (wb_en && wb_addr == instr[9:5])   ? wb_data : rf_q[instr[9:5]];
  assign rd_r2  = (wb_en && wb_addr == instr[14:10]) ? wb_data : rf_q[instr[14:10]];
  assign rd_dst = (wb_en && wb_addr == instr[4:0])   ? wb_data : rf_q[instr[4:0]];

  // Branch / LDRF condition one-hot {z, nz, c, nc} selected by ty.
  always_comb begin
    cond = 4'b0000;
    case (instr[27:26])
      2'd0: cond = 4'b1000;
      2'd1: cond = 4'b0100;
      2'd2: cond = 4'b0010;
      2'd3: cond = 4'b0001;
    endcase
  end

  // Instruction decode.
  always_comb begin
    dec         = '0;
    dec_ill     = 1'b0;
    dec.op      = instr[31:28];
    dec.ty      = instr[27:26];
    dec.alu     = instr[27:25];
    dec.ofs_r   = instr[25];
    dec.inc     = instr[24:22];
    dec.src_r2  = instr[14:10];
    dec.src_r1  = instr[9:5];
    dec.dst_r   = instr[4:0];
    dec.val_r1  = rd_r1;
    dec.val_dst = rd_dst;
    dec.val_r2  = instr[25] ? rd_r2 : {{17{instr[24]}}, instr[24:10]};
    dec.incr_r2 = {1'b0, instr[24:22]};
    inc_en      = (instr[23:22] != 2'b00) &&
                  (instr[25] || instr[31:28] == OP_ALU || instr[31:28] == OP_LDRF);
    case (instr[31:28])
      OP_LDR: begin
        dec.write_reg = 1'b1;
        case (instr[27:26])
          2'd1: begin
            dec.val_r1 = {instr[20:5], rd_dst[15:0]};
            inc_en     = 1'b0;
          end
          2'd2: begin
            dec.val_r1 = {rd_dst[31:16], instr[20:5]};
            inc_en     = 1'b0;
          end
          2'd3:    dec.read_mem = 1'b1;
          default: ;
        endcase
      end
      OP_STR: begin
        if (instr[27:26] == 2'd3) begin
          dec.write_mem = 1'b1;
        end else begin
          dec_ill = 1'b1;
          inc_en  = 1'b0;
        end
      end
      OP_JMPUNC: begin
        dec.jmpunc = 1'b1;
        case (instr[27:26])
          2'd0: begin
            dec.val_dst = {pc[31:26], instr[25:0]};
            inc_en      = 1'b0;
          end
          2'd1: dec.val_r1 = pc;
          2'd2: begin
            dec.val_r1    = pc;
            dec.write_reg = 1'b1;
          end
          default: ;
        endcase
      end
      OP_JMPF: begin
        dec.val_r1 = pc;
        {dec.jmpz, dec.jmpnz, dec.jmpc, dec.jmpnc} = cond;
      end
      OP_ALU: begin
        dec.val_r2    = rd_r2;
        dec.write_reg = (instr[27:25] != 3'd7);
        case (instr[27:25])
          3'd0: dec.and_op = 1'b1;
          3'd1: dec.or_op  = 1'b1;
          3'd2: dec.xor_op = 1'b1;
          3'd3: dec.add_op = 1'b1;
          3'd4: dec.mul_op = 1'b1;
          3'd5: dec.shl_op = 1'b1;
          3'd6: dec.shr_op = 1'b1;
          3'd7: dec.cmp_op = 1'b1;
        endcase
      end
      OP_LDRF: begin
        dec.ldrf_op   = 1'b1;
        dec.write_reg = 1'b1;
        dec.val_r2    = rd_r2;
        {dec.jmpz, dec.jmpnz, dec.jmpc, dec.jmpnc} = cond;
      end
      default: begin
        dec_ill = 1'b1;
        inc_en  = 1'b0;
      end
    endcase
    dec.incr_r2_enable = inc_en;
  end

  // Output register + skid buffer next state; flush wins over everything.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pipe_d  = out_pipe_q;
    out_ill_d   = out_ill_q;
    sk_valid_d  = sk_valid_q;
    sk_pipe_d   = sk_pipe_q;
    sk_ill_d    = sk_ill_q;
    accept      = instr_valid && !sk_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
      sk_valid_d  = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (sk_valid_q) begin
        // skid entry is older than anything fetch could offer now
        out_valid_d = 1'b1;
        out_pipe_d  = sk_pipe_q;
        out_ill_d   = sk_ill_q;
        sk_valid_d  = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_pipe_d  = dec;
        out_ill_d   = dec_ill;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_pipe_d  = dec;
      sk_ill_d   = dec_ill;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_valid_q <= 1'b0;
      out_pipe_q  <= '0;
      out_ill_q   <= 1'b0;
      sk_valid_q  <= 1'b0;
      sk_pipe_q   <= '0;
      sk_ill_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pipe_q  <= out_pipe_d;
      out_ill_q   <= out_ill_d;
      sk_valid_q  <= sk_valid_d;
      sk_pipe_q   <= sk_pipe_d;
      sk_ill_q    <= sk_ill_d;
    end
  end

  assign instr_ready = !sk_valid_q;
  assign out_valid   = out_valid_q;
  assign out_pipe    = out_pipe_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_qrisc32_decode.sv
// Bench for qrisc32_decode: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_qrisc32_decode;
  import risc_pack::*;

  localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         areset, flush, instr_valid, instr_ready;
  logic [31:0]  instr, pc;
  logic         out_valid, out_ready, out_illegal;
  pipe_struct_t out_pipe;
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qrisc32_decode #(.RF_RESET_VAL(RST_VAL)) dut (
    .clk(clk), .areset(areset), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pipe(out_pipe), .out_illegal(out_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct {
    pipe_struct_t p;
    logic         ill;
  } exp_t;

  exp_t        q[$];
  logic [31:0] rf_m [32];
  exp_t        m_e;
  logic        m_acc, m_con;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rfm(input logic [4:0] a);
    return (wb_en && wb_addr == a) ? wb_data : rf_m[a];
  endfunction

  function automatic logic [17:0] flags(input pipe_struct_t p);
    return {p.incr_r2_enable, p.read_mem, p.write_mem, p.write_reg, p.jmpunc,
            p.jmpz, p.jmpnz, p.jmpc, p.jmpnc, p.and_op, p.or_op, p.xor_op,
            p.add_op, p.mul_op, p.shl_op, p.shr_op, p.cmp_op, p.ldrf_op};
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t model_dec(input logic [31:0] w, input logic [31:0] p);
    exp_t        e;
    logic [3:0]  op;
    logic [1:0]  ty;
    logic [3:0]  cnd;
    logic [7:0]  aoh;
    logic [31:0] d;
    logic        en;
    op = w[31:28];
    ty = w[27:26];
    d  = rfm(w[4:0]);
    e.p = '0;
    e.ill = 1'b0;
    e.p.op = op; e.p.ty = ty; e.p.alu = w[27:25]; e.p.ofs_r = w[25];
    e.p.inc = w[24:22]; e.p.src_r2 = w[14:10]; e.p.src_r1 = w[9:5]; e.p.dst_r = w[4:0];
    e.p.val_r1  = rfm(w[9:5]);
    e.p.val_dst = d;
    e.p.val_r2  = w[25] ? rfm(w[14:10]) : 32'($signed(w[24:10]));
    e.p.incr_r2 = {1'b0, w[24:22]};
    en  = (w[23:22] != 2'b00) && (w[25] || op == 4'd4 || op == 4'd5);
    cnd = 4'b1000 >> ty;
    aoh = 8'b1000_0000 >> w[27:25];
    if (op == 4'd0) begin
      e.p.write_reg = 1'b1;
      if (ty == 2'd1) begin e.p.val_r1 = {w[20:5], d[15:0]}; en = 1'b0; end
      if (ty == 2'd2) begin e.p.val_r1 = {d[31:16], w[20:5]}; en = 1'b0; end
      if (ty == 2'd3) e.p.read_mem = 1'b1;
    end else if (op == 4'd1 && ty == 2'd3) begin
      e.p.write_mem = 1'b1;
    end else if (op == 4'd2) begin
      e.p.jmpunc = 1'b1;
      if (ty == 2'd0) begin e.p.val_dst = {p[31:26], w[25:0]}; en = 1'b0; end
      if (ty == 2'd1 || ty == 2'd2) e.p.val_r1 = p;
      if (ty == 2'd2) e.p.write_reg = 1'b1;
    end else if (op == 4'd3) begin
      e.p.val_r1 = p;
      {e.p.jmpz, e.p.jmpnz, e.p.jmpc, e.p.jmpnc} = cnd;
    end else if (op == 4'd4) begin
      e.p.val_r2 = rfm(w[14:10]);
      {e.p.and_op, e.p.or_op, e.p.xor_op, e.p.add_op,
       e.p.mul_op, e.p.shl_op, e.p.shr_op, e.p.cmp_op} = aoh;
      e.p.write_reg = !e.p.cmp_op;
    end else if (op == 4'd5) begin
      e.p.ldrf_op = 1'b1;
      e.p.write_reg = 1'b1;
      e.p.val_r2 = rfm(w[14:10]);
      {e.p.jmpz, e.p.jmpnz, e.p.jmpc, e.p.jmpnc} = cnd;
    end else begin
      e.ill = 1'b1;
      en = 1'b0;
    end
    e.p.incr_r2_enable = en;
    return e;
  endfunction

  // Model: the queue holds every instruction inside decode, oldest first.
  always @(negedge clk) begin
    if (areset) begin
      q.delete();
      for (int i = 0; i < 32; i++) rf_m[i] = RST_VAL;
      chk("reset_out_valid", 160'(out_valid), 160'(1'b0));
      chk("reset_instr_ready", 160'(instr_ready), 160'(1'b1));
    end else begin
      chk("out_valid", 160'(out_valid), 160'(q.size() != 0));
      chk("instr_ready", 160'(instr_ready), 160'(q.size() < 2));
      if (q.size() != 0 && out_valid) begin
        chk("out_pipe", 160'(out_pipe), 160'(q[0].p));
        chk("out_illegal", 160'(out_illegal), 160'(q[0].ill));
      end
      m_e   = model_dec(instr, pc);
      m_acc = instr_valid && (q.size() < 2);
      m_con = (q.size() != 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (m_con) void'(q.pop_front());
        if (m_acc) q.push_back(m_e);
      end
      if (wb_en) rf_m[wb_addr] = wb_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] ty,
                                      input logic ofs, input logic [14:0] imm,
                                      input logic [4:0] s1, input logic [4:0] d);
    return {op, ty, ofs, imm, s1, d};
  endfunction

  logic [31:0] bp_w [6];
  logic        pat  [12];
  int          sent, got, c;
  logic        saw_full;

  initial begin
    areset = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0;
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_pipe", 160'(out_pipe), 160'(0));
    chk("rst_out_illegal", 160'(out_illegal), 160'(0));
    chk("rst_ready", 160'(instr_ready), 160'(1));
    areset = 1'b0;

    // ADD R1,R3,R3 after writing R3
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234_5678;
    cyc();
    wb_en = 1'b0;
    instr = enc(4'd4, 2'b01, 1'b1, {3'b000, 7'd0, 5'd3}, 5'd3, 5'd1); pc = 32'h40;
    instr_valid = 1'b1;
    cyc();
    chk("add_valid", 160'(out_valid), 160'(1));
    chk("add_op", 160'(out_pipe.add_op), 160'(1));
    chk("add_wreg", 160'(out_pipe.write_reg), 160'(1));
    chk("add_r1", 160'(out_pipe.val_r1), 160'(32'h1234_5678));
    chk("add_r2", 160'(out_pipe.val_r2), 160'(32'h1234_5678));
    chk("add_incen", 160'(out_pipe.incr_r2_enable), 160'(0));

    // LDRH R2,0xABCD with same-cycle write of R2
    instr = {4'd0, 2'd1, 1'b0, 4'd0, 16'hABCD, 5'd2};
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_1111;
    cyc();
    wb_en = 1'b0;
    chk("ldrh_r1", 160'(out_pipe.val_r1), 160'(32'hABCD_1111));
    chk("ldrh_wreg", 160'(out_pipe.write_reg), 160'(1));

    // CALL R4, offset -4
    instr = enc(4'd2, 2'd2, 1'b0, 15'h7FFC, 5'd0, 5'd4); pc = 32'h100;
    cyc();
    chk("call_jmp", 160'(out_pipe.jmpunc), 160'(1));
    chk("call_wreg", 160'(out_pipe.write_reg), 160'(1));
    chk("call_r1", 160'(out_pipe.val_r1), 160'(32'h100));
    chk("call_r2", 160'(out_pipe.val_r2), 160'(32'hFFFF_FFFC));

    // Illegal opcodes
    instr = enc(4'hF, 2'd3, 1'b1, 15'h1234, 5'd7, 5'd8);
    cyc();
    chk("opF_illegal", 160'(out_illegal), 160'(1));
    chk("opF_flags", 160'(flags(out_pipe)), 160'(0));
    instr = enc(4'd1, 2'd0, 1'b1, 15'h1C00, 5'd2, 5'd3);
    cyc();
    chk("str0_illegal", 160'(out_illegal), 160'(1));
    chk("str0_flags", 160'(flags(out_pipe)), 160'(0));
    instr_valid = 1'b0;
    cyc();

    // Backpressure stream of six
    bp_w[0] = enc(4'd4, 2'b01, 1'b0, {3'b011, 7'd0, 5'd3}, 5'd2, 5'd11);
    bp_w[1] = enc(4'd3, 2'd2, 1'b1, {3'b001, 7'd5, 5'd4}, 5'd3, 5'd12);
    bp_w[2] = enc(4'd5, 2'd1, 1'b0, 15'h4005, 5'd1, 5'd13);
    bp_w[3] = enc(4'd0, 2'd3, 1'b1, {3'b110, 7'd0, 5'd7}, 5'd6, 5'd14);
    bp_w[4] = enc(4'd1, 2'd3, 1'b0, 15'h0ABC, 5'd5, 5'd15);
    bp_w[5] = enc(4'd2, 2'd0, 1'b1, 15'h7FFF, 5'd31, 5'd16);
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    sent = 0; got = 0; c = 0; saw_full = 1'b0;
    while ((sent < 6 || got < 6) && c < 40) begin
      instr_valid = (sent < 6);
      instr = bp_w[(sent < 6) ? sent : 0];
      pc = 32'h0400_0200 + 32'(4 * sent);
      out_ready = (c < 12) ? pat[c] : 1'b1;
      wb_en = (c % 3 == 0); wb_addr = 5'(c); wb_data = 32'hA000_0000 + 32'(c);
      if (!instr_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        chk("bp_order", 160'(out_pipe.dst_r), 160'(got + 11));
        got++;
      end
      if (instr_valid && instr_ready) sent++;
      cyc();
      c++;
    end
    instr_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    chk("bp_sent", 160'(sent), 160'(6));
    chk("bp_got", 160'(got), 160'(6));
    chk("bp_saw_full", 160'(saw_full), 160'(1));
    cyc();

    // Flush with OUT and SK full and a word on offer
    out_ready = 1'b0; instr_valid = 1'b1;
    instr = enc(4'd4, 2'b11, 1'b1, 15'd1, 5'd1, 5'd20);
    cyc();
    instr = enc(4'd4, 2'b10, 1'b0, 15'd2, 5'd2, 5'd21);
    cyc();
    chk("full_ready", 160'(instr_ready), 160'(0));
    flush = 1'b1; out_ready = 1'b1;
    instr = enc(4'd4, 2'b00, 1'b0, 15'd3, 5'd3, 5'd22);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0F0F_0F0F;
    cyc();
    flush = 1'b0; instr_valid = 1'b0; wb_en = 1'b0;
    chk("flush_valid", 160'(out_valid), 160'(0));
    chk("flush_ready", 160'(instr_ready), 160'(1));
    cyc();
    chk("flush_stays_empty", 160'(out_valid), 160'(0));
    instr = enc(4'd4, 2'b00, 1'b0, 15'd9, 5'd9, 5'd1); instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    chk("write_under_flush", 160'(out_pipe.val_r1), 160'(32'h0F0F_0F0F));

    // Asynchronous reset mid-stream
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555_AAAA;
    out_ready = 1'b0; instr_valid = 1'b1;
    instr = enc(4'd4, 2'b01, 1'b1, 15'd5, 5'd5, 5'd6);
    cyc();
    wb_en = 1'b0;
    cyc();
    #2 areset = 1'b1;
    #1;
    chk("areset_valid", 160'(out_valid), 160'(0));
    chk("areset_ready", 160'(instr_ready), 160'(1));
    @(posedge clk);
    #1 areset = 1'b0;
    instr = enc(4'd4, 2'b01, 1'b1, {3'b000, 7'd0, 5'd3}, 5'd5, 5'd2);
    out_ready = 1'b1; instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    chk("areset_rf_r5", 160'(out_pipe.val_r1), 160'(RST_VAL));
    chk("areset_rf_r3", 160'(out_pipe.val_r2), 160'(RST_VAL));
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
